iobus_timer_responder: RTL and testbench
========================================

// Module: iobus_timer_responder
// PURPOSE
//  Memory-mapped machine timer on the IOBUS; the responder end of the MCU's IOBUS_ADDR/IOBUS_OUT/IOBUS_WR/IOBUS_IN
//  initiator port. Holds 64-bit mtime / mtimecmp with a prescaler, one-shot or periodic (auto-reload) compare,
//  and a sticky pending flag. Drives the MCU's timer_int input. Instantiated at the board top level beside the MCU.
// PARAMETERS
//  BASE_ADDR   32'h1100_0200  word-aligned base of the 32-byte register window (ADDR[31:5] must match BASE_ADDR[31:5])
//  PRESCALE_W  8              width of CTRL.PRESCALE and of the prescale counter
// PORTS
//  CLK         in   1   system clock; all logic on posedge CLK
//  RST_N       in   1   reset, synchronous, active-low
//  IOBUS_ADDR  in   32  byte address from MCU; bits [1:0] ignored
//  IOBUS_OUT   in   32  write data from MCU
//  IOBUS_WR    in   1   write strobe, one cycle per store
//  IOBUS_IN    out  32  read data to MCU; 0 when the window is not hit
//  io_hit      out  1   registered: previous-cycle address was inside the window (top-level read-mux select)
//  timer_int   out  1   level interrupt to MCU = STATUS.PEND & CTRL.IE
// BEHAVIOUR
//  Register map (offset: name, access):
//   0x00 MTIME_LO RW | 0x04 MTIME_HI RW | 0x08 MTIMECMP_LO RW | 0x0C MTIMECMP_HI RW | 0x10 PERIOD RW
//   0x14 CTRL RW: [0] EN, [1] PERIODIC, [2] IE, [8+:PRESCALE_W] PRESCALE; all other bits read 0
//   0x18 STATUS: [0] PEND (sticky, write-1-to-clear), [1] MATCH (live, read-only); 0x1C reads 0, writes ignored
//  Reset (RST_N low at posedge): mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, PERIOD=0, CTRL=0, PEND=0,
//   prescale count=0, IOBUS_IN=0, io_hit=0, timer_int=0. Reset mid-count or with PEND set: everything returns to reset values.
//  Writes: full 32-bit only (no byte lanes). Take effect at the posedge where IOBUS_WR=1 and address hits.
//  Reads: no read strobe, no read side effects. Every cycle IOBUS_IN <= selected register (0 if miss);
//   data for address presented in cycle N is valid in cycle N+1. Same-cycle write+read of a register returns the old value.
//  Prescaler: count runs only when EN=1; tick when count==PRESCALE, count then returns to 0. PRESCALE=0 -> tick every cycle.
//   EN=0 holds count at 0. Writing CTRL clears count.
//  mtime: 64-bit unsigned, +1 on each tick, carry lo->hi, wraps 2^64-1 -> 0. SW write to either half in a tick cycle:
//   written half takes IOBUS_OUT, other half keeps its value (no increment that cycle).
//  MATCH = EN & (mtime >= mtimecmp), 64-bit unsigned compare on registered values.
//  PEND: set at the posedge where MATCH=1. W1C of PEND in the same cycle MATCH=1: set wins.
//  Periodic (PERIODIC=1): at the posedge where MATCH=1, mtimecmp <= mtimecmp + {32'b0,PERIOD} (mod 2^64).
//   SW write to MTIMECMP_LO/HI in the same cycle wins over reload (written half from SW, other half held).
//   PERIOD=0: MATCH stays true, PEND re-sets every cycle (documented, not an error).
//  One-shot (PERIODIC=0): mtimecmp untouched; PEND re-sets every cycle while MATCH holds; SW must move mtimecmp.
//  timer_int: combinational AND of flop outputs PEND & IE; rises one cycle after the first MATCH cycle.
//   IE=0 masks output but PEND still sets.
// STRUCTURE
//  Package iobus_timer_pkg: register offset localparams, CTRL/STATUS bit-position localparams,
//   MTIMECMP_RST constant, register-select enum.
//  Sub-module timer_prescaler (EN, PRESCALE, clear -> tick). Rest (regs, compare, reload, read mux) in this module.
// TESTING
//  1 Reset: hold RST_N=0 3 cycles with random bus -> IOBUS_IN=0, timer_int=0; read MTIMECMP_HI -> 32'hFFFF_FFFF.
//  2 Write MTIME_LO=5, MTIMECMP_LO=10, MTIMECMP_HI=0, CTRL=0x5 (EN,IE, PRESCALE=0) -> timer_int rises
//    exactly 1 cycle after mtime reaches 10; read STATUS -> 0x3.
//  3 CTRL PRESCALE=3, EN=1 from mtime=0 -> mtime=1 after 4 cycles, mtime=100 after 400 cycles.
//  4 MTIME_LO=32'hFFFF_FFFE, HI=0, PRESCALE=0 -> after 2 ticks HI=1, LO=0; MTIME=all ones -> wraps to 0.
//  5 Periodic: CMP=20, PERIOD=8, CTRL=0x7 -> CMP reads 28, 36, 44 at successive matches; W1C PEND between them
//    clears timer_int until next match; W1C on a match cycle leaves PEND=1.
//  6 Write MTIME_LO on a tick cycle and MTIMECMP_LO on a reload cycle -> SW values win;
//    address 0x1100_0300 -> IOBUS_IN=0, io_hit=0, no register changes.

Source files
------------

// File: rtl/iobus_timer_pkg.sv
// Shared definitions for the IOBUS machine timer: register offsets,
// CTRL/STATUS bit positions, reset constants and the register-select decode.
package iobus_timer_pkg;

  localparam logic [4:0] OFF_MTIME_LO    = 5'h00;
  localparam logic [4:0] OFF_MTIME_HI    = 5'h04;
  localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] OFF_PERIOD      = 5'h10;
  localparam logic [4:0] OFF_CTRL        = 5'h14;
  localparam logic [4:0] OFF_STATUS      = 5'h18;

  localparam int unsigned CTRL_EN           = 0;
  localparam int unsigned CTRL_PERIODIC     = 1;
  localparam int unsigned CTRL_IE           = 2;
  localparam int unsigned CTRL_PRESCALE_LSB = 8;

  localparam int unsigned STAT_PEND  = 0;
  localparam int unsigned STAT_MATCH = 1;

  localparam logic [63:0] MTIMECMP_RST = '1;

  typedef enum logic [2:0] {
    SEL_MTIME_LO,
    SEL_MTIME_HI,
    SEL_MTIMECMP_LO,
    SEL_MTIMECMP_HI,
    SEL_PERIOD,
    SEL_CTRL,
    SEL_STATUS,
    SEL_NONE
  } reg_sel_e;

  // Byte offset within the window to register select; bits [1:0] are ignored.
  function automatic reg_sel_e decode_sel(input logic [4:0] off);
    reg_sel_e sel;
    case (off & 5'h1C)
      OFF_MTIME_LO:    sel = SEL_MTIME_LO;
      OFF_MTIME_HI:    sel = SEL_MTIME_HI;
      OFF_MTIMECMP_LO: sel = SEL_MTIMECMP_LO;
      OFF_MTIMECMP_HI: sel = SEL_MTIMECMP_HI;
      OFF_PERIOD:      sel = SEL_PERIOD;
      OFF_CTRL:        sel = SEL_CTRL;
      OFF_STATUS:      sel = SEL_STATUS;
      default:         sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/iobus_timer_responder_prescaler.sv
// Prescaler for the machine timer: emits one tick every PRESCALE+1 enabled
// cycles. Disabled or cleared, the count sits at zero.
module timer_prescaler #(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  clear,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] count;

  assign tick = en & (count == prescale);

  // Count up to PRESCALE, then wrap to zero on the tick cycle
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      count <= '0;
    end else if (clear || !en || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/iobus_timer_responder.sv
// Memory-mapped 64-bit machine timer on the IOBUS: mtime/mtimecmp with a
// prescaler, one-shot or auto-reload compare, sticky pending flag and a
// level interrupt towards the MCU.
module iobus_timer_responder
  import iobus_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1100_0200,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        io_hit,
  output logic        timer_int
);

  logic [63:0]           mtime;
  logic [63:0]           mtimecmp;
  logic [31:0]           period;
  logic                  ctrl_en;
  logic                  ctrl_periodic;
  logic                  ctrl_ie;
  logic [PRESCALE_W-1:0] ctrl_prescale;
  logic                  pend;
  logic                  tick;
  logic                  match;
  logic                  hit;
  reg_sel_e              sel;
  logic                  wr_hit;
  logic                  wr_mtime_lo;
  logic                  wr_mtime_hi;
  logic                  wr_cmp_lo;
  logic                  wr_cmp_hi;
  logic                  wr_period;
  logic                  wr_ctrl;
  logic                  wr_status;
  logic [31:0]           ctrl_word;
  logic [31:0]           status_word;
  logic [31:0]           rd_mux;

  assign hit    = (IOBUS_ADDR[31:5] == BASE_ADDR[31:5]);
  assign sel    = decode_sel(IOBUS_ADDR[4:0]);
  assign wr_hit = IOBUS_WR & hit;

  assign wr_mtime_lo = wr_hit & (sel == SEL_MTIME_LO);
  assign wr_mtime_hi = wr_hit & (sel == SEL_MTIME_HI);
  assign wr_cmp_lo   = wr_hit & (sel == SEL_MTIMECMP_LO);
  assign wr_cmp_hi   = wr_hit & (sel == SEL_MTIMECMP_HI);
  assign wr_period   = wr_hit & (sel == SEL_PERIOD);
  assign wr_ctrl     = wr_hit & (sel == SEL_CTRL);
  assign wr_status   = wr_hit & (sel == SEL_STATUS);

  assign match     = ctrl_en & (mtime >= mtimecmp);
  assign timer_int = pend & ctrl_ie;

  timer_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .en       (ctrl_en),
    .prescale (ctrl_prescale),
    .clear    (wr_ctrl),
    .tick     (tick)
  );

  // mtime: a software write to either half replaces that half and suppresses
  // the tick increment for the cycle
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      mtime <= '0;
    end else if (wr_mtime_lo) begin
      mtime[31:0] <= IOBUS_OUT;
    end else if (wr_mtime_hi) begin
      mtime[63:32] <= IOBUS_OUT;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  // mtimecmp: software write wins over the periodic reload
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      mtimecmp <= MTIMECMP_RST;
    end else if (wr_cmp_lo) begin
      mtimecmp[31:0] <= IOBUS_OUT;
    end else if (wr_cmp_hi) begin
      mtimecmp[63:32] <= IOBUS_OUT;
    end else if (match && ctrl_periodic) begin
      mtimecmp <= mtimecmp + {32'b0, period};
    end
  end

  // PERIOD and CTRL configuration registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      period        <= '0;
      ctrl_en       <= 1'b0;
      ctrl_periodic <= 1'b0;
      ctrl_ie       <= 1'b0;
      ctrl_prescale <= '0;
    end else begin
      if (wr_period) begin
        period <= IOBUS_OUT;
      end
      if (wr_ctrl) begin
        ctrl_en       <= IOBUS_OUT[CTRL_EN];
        ctrl_periodic <= IOBUS_OUT[CTRL_PERIODIC];
        ctrl_ie       <= IOBUS_OUT[CTRL_IE];
        ctrl_prescale <= IOBUS_OUT[CTRL_PRESCALE_LSB +: PRESCALE_W];
      end
    end
  end

  // Sticky pending flag: a match in the same cycle as write-1-to-clear keeps it set
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pend <= 1'b0;
    end else if (match) begin
      pend <= 1'b1;
    end else if (wr_status && IOBUS_OUT[STAT_PEND]) begin
      pend <= 1'b0;
    end
  end

  // Assemble the CTRL and STATUS read words; undefined bits read zero
  always_comb begin
    ctrl_word                                     = '0;
    ctrl_word[CTRL_EN]                            = ctrl_en;
    ctrl_word[CTRL_PERIODIC]                      = ctrl_periodic;
    ctrl_word[CTRL_IE]                            = ctrl_ie;
    ctrl_word[CTRL_PRESCALE_LSB +: PRESCALE_W]    = ctrl_prescale;
    status_word                                   = '0;
    status_word[STAT_PEND]                        = pend;
    status_word[STAT_MATCH]                       = match;
  end

  // Read mux over current register values; misses return zero
  always_comb begin
    rd_mux = '0;
    if (hit) begin
      case (sel)
        SEL_MTIME_LO:    rd_mux = mtime[31:0];
        SEL_MTIME_HI:    rd_mux = mtime[63:32];
        SEL_MTIMECMP_LO: rd_mux = mtimecmp[31:0];
        SEL_MTIMECMP_HI: rd_mux = mtimecmp[63:32];
        SEL_PERIOD:      rd_mux = period;
        SEL_CTRL:        rd_mux = ctrl_word;
        SEL_STATUS:      rd_mux = status_word;
        default:         rd_mux = '0;
      endcase
    end
  end

  // Registered read data and window-hit flag for the top-level read mux
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      IOBUS_IN <= '0;
      io_hit   <= 1'b0;
    end else begin
      IOBUS_IN <= rd_mux;
      io_hit   <= hit;
    end
  end

endmodule

// File: tb/tb_iobus_timer_responder.sv
// Self-checking bench for iobus_timer_responder: directed scenarios plus a
// randomized bus phase, all compared against a behavioural register model.
module tb_iobus_timer_responder;

  localparam logic [31:0] BASE = 32'h1100_0200;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] IOBUS_ADDR = '0;
  logic [31:0] IOBUS_OUT = '0;
  logic        IOBUS_WR = 1'b0;
  logic [31:0] IOBUS_IN;
  logic        io_hit;
  logic        timer_int;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  iobus_timer_responder #(
    .BASE_ADDR  (BASE),
    .PRESCALE_W (8)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .IOBUS_IN   (IOBUS_IN),
    .io_hit     (io_hit),
    .timer_int  (timer_int)
  );

  // Reference state, kept as plain numbers
  longint unsigned m_time = 0;
  longint unsigned m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
  logic [31:0]     m_period = '0;
  bit              m_en = 0, m_per = 0, m_ie = 0, m_pend = 0, m_hit = 0;
  int unsigned     m_pre = 0, m_cnt = 0;
  logic [31:0]     m_rd = '0;

  function automatic logic [31:0] m_read(input logic [4:0] off);
    logic [31:0] v;
    bit mt;
    mt = m_en && (m_time >= m_cmp);
    case (off)
      5'h00:   v = m_time[31:0];
      5'h04:   v = m_time[63:32];
      5'h08:   v = m_cmp[31:0];
      5'h0C:   v = m_cmp[63:32];
      5'h10:   v = m_period;
      5'h14:   v = (m_pre << 8) | (32'(m_ie) << 2) | (32'(m_per) << 1) | 32'(m_en);
      5'h18:   v = (32'(mt) << 1) | 32'(m_pend);
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive, advance the model across the edge, compare outputs
  task automatic step(input logic [31:0] a, input logic [31:0] d, input bit w);
    bit hit, wr, mt, tk;
    logic [4:0] off;
    logic [31:0] rd;
    longint unsigned n_time, n_cmp;
    IOBUS_ADDR = a;
    IOBUS_OUT  = d;
    IOBUS_WR   = w;
    hit = (a[31:5] == BASE[31:5]);
    off = a[4:0] & 5'h1C;
    wr  = w && hit;
    rd  = hit ? m_read(off) : 32'h0;
    mt  = m_en && (m_time >= m_cmp);
    tk  = m_en && (m_cnt == m_pre);
    @(posedge CLK);
    if (!RST_N) begin
      m_time = 0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_period = '0;
      m_en = 0; m_per = 0; m_ie = 0; m_pre = 0; m_cnt = 0; m_pend = 0;
      m_rd = '0; m_hit = 0;
    end else begin
      n_time = m_time;
      if (wr && off == 5'h00)      n_time = {m_time[63:32], d};
      else if (wr && off == 5'h04) n_time = {d, m_time[31:0]};
      else if (tk)                 n_time = m_time + 1;
      n_cmp = m_cmp;
      if (wr && off == 5'h08)      n_cmp = {m_cmp[63:32], d};
      else if (wr && off == 5'h0C) n_cmp = {d, m_cmp[31:0]};
      else if (mt && m_per)        n_cmp = m_cmp + longint'(m_period);
      if (wr && off == 5'h14 || !m_en || tk) m_cnt = 0;
      else                                    m_cnt = m_cnt + 1;
      if (mt)                                   m_pend = 1;
      else if (wr && off == 5'h18 && d[0])      m_pend = 0;
      if (wr && off == 5'h10) m_period = d;
      if (wr && off == 5'h14) begin
        m_en = d[0]; m_per = d[1]; m_ie = d[2]; m_pre = int'(d[15:8]);
      end
      m_time = n_time;
      m_cmp  = n_cmp;
      m_rd   = rd;
      m_hit  = hit;
    end
    #1;
    chk("iobus_in", IOBUS_IN, m_rd);
    chk("io_hit", {31'b0, io_hit}, {31'b0, m_hit});
    chk("timer_int", {31'b0, timer_int}, {31'b0, m_pend && m_ie});
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] d);
    step(BASE + 32'(off), d, 1'b1);
  endtask

  task automatic rd(input logic [4:0] off);
    step(BASE + 32'(off), $urandom, 1'b0);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(32'h0000_1000, $urandom, 1'b0);
  endtask

  initial begin
    // Reset with a noisy bus
    RST_N = 1'b0;
    for (int i = 0; i < 3; i++) step($urandom, $urandom, 1'b1);
    chk("rst_iobus_in", IOBUS_IN, 32'h0);
    chk("rst_timer_int", {31'b0, timer_int}, 32'h0);
    RST_N = 1'b1;
    rd(5'h0C);
    chk("rst_cmp_hi", IOBUS_IN, 32'hFFFF_FFFF);

    // One-shot compare, interrupt one cycle after mtime reaches 10
    wr(5'h00, 32'd5);
    wr(5'h08, 32'd10);
    wr(5'h0C, 32'd0);
    wr(5'h14, 32'h5);
    idle(5);
    chk("int_before_match", {31'b0, timer_int}, 32'h0);
    idle(1);
    chk("int_after_match", {31'b0, timer_int}, 32'h1);
    rd(5'h18);
    chk("status_match_pend", IOBUS_IN, 32'h3);

    // Prescaler = 3
    wr(5'h14, 32'h0);
    wr(5'h08, 32'hFFFF_FFFF);
    wr(5'h0C, 32'hFFFF_FFFF);
    wr(5'h00, 32'h0);
    wr(5'h04, 32'h0);
    wr(5'h18, 32'h1);
    wr(5'h14, 32'h0000_0301);
    idle(4);
    rd(5'h00);
    chk("presc_mtime_1", IOBUS_IN, 32'd1);
    idle(395);
    rd(5'h00);
    chk("presc_mtime_100", IOBUS_IN, 32'd100);

    // Carry from low to high word, and full 64-bit wrap
    wr(5'h14, 32'h0);
    wr(5'h00, 32'hFFFF_FFFE);
    wr(5'h04, 32'h0);
    wr(5'h14, 32'h1);
    idle(2);
    rd(5'h00);
    chk("carry_lo", IOBUS_IN, 32'h0);
    rd(5'h04);
    chk("carry_hi", IOBUS_IN, 32'h1);
    wr(5'h14, 32'h0);
    wr(5'h00, 32'hFFFF_FFFF);
    wr(5'h04, 32'hFFFF_FFFF);
    wr(5'h14, 32'h1);
    idle(1);
    rd(5'h00);
    chk("wrap_lo", IOBUS_IN, 32'h0);
    rd(5'h04);
    chk("wrap_hi", IOBUS_IN, 32'h0);

    // Periodic reload, W1C between matches and on a match cycle
    wr(5'h14, 32'h0);
    wr(5'h00, 32'h0);
    wr(5'h04, 32'h0);
    wr(5'h08, 32'd20);
    wr(5'h0C, 32'h0);
    wr(5'h10, 32'd8);
    wr(5'h18, 32'h1);
    wr(5'h14, 32'h7);
    idle(21);
    rd(5'h08);
    chk("reload_28", IOBUS_IN, 32'd28);
    chk("int_first_period", {31'b0, timer_int}, 32'h1);
    wr(5'h18, 32'h1);
    chk("int_cleared", {31'b0, timer_int}, 32'h0);
    idle(5);
    chk("int_still_clear", {31'b0, timer_int}, 32'h0);
    idle(1);
    chk("int_second_period", {31'b0, timer_int}, 32'h1);
    rd(5'h08);
    chk("reload_36", IOBUS_IN, 32'd36);
    idle(6);
    wr(5'h18, 32'h1);
    chk("w1c_on_match_keeps", {31'b0, timer_int}, 32'h1);
    rd(5'h08);
    chk("reload_44", IOBUS_IN, 32'd44);

    // Software write beats tick and reload
    wr(5'h00, 32'h0000_1000);
    rd(5'h00);
    chk("sw_mtime_wins", IOBUS_IN, 32'h0000_1000);
    wr(5'h14, 32'h0);
    wr(5'h00, 32'd50);
    wr(5'h04, 32'h0);
    wr(5'h08, 32'd50);
    wr(5'h0C, 32'h0);
    wr(5'h14, 32'h7);
    wr(5'h08, 32'h0000_0500);
    rd(5'h08);
    chk("sw_cmp_wins", IOBUS_IN, 32'h0000_0500);
    rd(5'h0C);
    chk("sw_cmp_hi_held", IOBUS_IN, 32'h0);

    // Outside the window: no hit, zero data, nothing changes
    step(32'h1100_0300, 32'hDEAD_BEEF, 1'b1);
    chk("miss_iobus_in", IOBUS_IN, 32'h0);
    chk("miss_io_hit", {31'b0, io_hit}, 32'h0);
    step(32'h1100_0310, 32'h0000_0000, 1'b1);
    rd(5'h10);
    chk("miss_period_kept", IOBUS_IN, 32'd8);
    wr(5'h1C, 32'hFFFF_FFFF);
    rd(5'h1C);
    chk("reserved_reads_0", IOBUS_IN, 32'h0);

    // Randomized bus traffic against the model
    for (int i = 0; i < 400; i++) begin
      int unsigned k;
      logic [31:0] a, d;
      k = $urandom_range(0, 8);
      a = (k == 8) ? (BASE + 32'h100 + ($urandom & 32'h1F)) : (BASE + 32'(k * 4) + ($urandom & 32'h3));
      case (k)
        0, 2:    d = $urandom_range(0, 300);
        1, 3:    d = ($urandom_range(0, 7) == 0) ? 32'h1 : 32'h0;
        4:       d = $urandom_range(0, 20);
        5:       d = ($urandom & 32'hFFFF_00F8) | 32'($urandom_range(0, 7)) | (32'($urandom_range(0, 3)) << 8);
        default: d = $urandom;
      endcase
      if (k == 5) d[15:10] = '0;
      step(a, d, ($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of activity
    RST_N = 1'b0;
    for (int i = 0; i < 2; i++) step(BASE + ($urandom & 32'h1F), $urandom, 1'b1);
    RST_N = 1'b1;
    rd(5'h0C);
    chk("rerst_cmp_hi", IOBUS_IN, 32'hFFFF_FFFF);
    rd(5'h18);
    chk("rerst_status", IOBUS_IN, 32'h0);
    rd(5'h14);
    chk("rerst_ctrl", IOBUS_IN, 32'h0);
    rd(5'h00);
    chk("rerst_mtime_lo", IOBUS_IN, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
